// File: rtl/ic_pkg.sv
// rtl/ic_pkg.sv - shared types and default widths for the interconnect slave-port arbiter
package ic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam int          DEF_N            = 32;
  localparam int          DEF_SEL_W        = 1;
  localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/slave_port_arbiter_rr_picker.sv
// rtl/slave_port_arbiter_rr_picker.sv - combinational round-robin picker, first set bit at or above ptr with wrap
module rr_picker
  import ic_pkg::*;
#(
  parameter int MASTERS = 2,
  parameter int PW      = $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0] elig,
  input  logic [PW-1:0]      ptr,
  output logic [MASTERS-1:0] winner,
  output logic [PW-1:0]      winner_idx
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int k = 0; k < MASTERS; k++) begin
      w_idx = PW'((int'(ptr) + k) % MASTERS);
      if (!w_found && elig[w_idx]) begin
        w_found       = 1'b1;
        winner[w_idx] = 1'b1;
        winner_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/slave_port_arbiter.sv
// rtl/slave_port_arbiter.sv - per-slave-port round-robin arbiter with grant locked until slave ack
// Optional abort of stalled transactions when ARB_TIMEOUT_EN is defined.
module slave_port_arbiter
  import ic_pkg::*;
#(
  parameter int MASTERS  = 2,
  parameter int N        = DEF_N,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int SLAVE_ID = 0
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int          TIMEOUT      = 16,
  parameter logic [N-1:0] TIMEOUT_DATA = N'(DEF_TIMEOUT_DATA)
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MASTERS-1:0]   m_req,
  input  logic [MASTERS*N-1:0] m_addr,
  input  logic [MASTERS-1:0]   m_cmd,
  input  logic [MASTERS*N-1:0] m_wdata,
  output logic [MASTERS-1:0]   m_ack,
  output logic [N-1:0]         m_rdata,
  output logic                 s_req,
  output logic [N-1:0]         s_addr,
  output logic                 s_cmd,
  output logic [N-1:0]         s_wdata,
  input  logic                 s_ack,
  input  logic [N-1:0]         s_rdata,
  output logic [MASTERS-1:0]   arb_req,
  output logic [MASTERS-1:0]   arb_grant,
  output logic                 timeout
);

  localparam int PW = $clog2(MASTERS);

  arb_state_t          r_state;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_gidx;
  logic [MASTERS-1:0]  r_grant;
  logic [MASTERS-1:0]  r_m_ack;
  logic [N-1:0]        r_m_rdata;
  logic                r_s_req;
  logic [N-1:0]        r_s_addr;
  logic                r_s_cmd;
  logic [N-1:0]        r_s_wdata;

  logic [MASTERS-1:0]  w_elig;
  logic [MASTERS-1:0]  w_winner;
  logic [PW-1:0]       w_win_idx;
  logic [PW-1:0]       w_ptr_next;
  logic                w_done;

  for (genvar gi = 0; gi < MASTERS; gi++) begin : g_elig
    assign w_elig[gi] = m_req[gi] && (m_addr[gi*N + N - 1 -: SEL_W] == SEL_W'(SLAVE_ID));
  end

  rr_picker #(
    .MASTERS (MASTERS),
    .PW      (PW)
  ) u_picker (
    .elig       (w_elig),
    .ptr        (r_ptr),
    .winner     (w_winner),
    .winner_idx (w_win_idx)
  );

  assign w_ptr_next = (r_gidx == PW'(MASTERS - 1)) ? '0 : r_gidx + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_timeout;
  logic          w_expire;

  assign w_expire = (r_cnt == CW'(TIMEOUT - 1));
  assign w_done   = s_ack || w_expire;
  assign timeout  = r_timeout;
`else
  assign w_done   = s_ack;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_grant   <= '0;
      r_m_ack   <= '0;
      r_m_rdata <= '0;
      r_s_req   <= 1'b0;
      r_s_addr  <= '0;
      r_s_cmd   <= 1'b0;
      r_s_wdata <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_elig) begin
            r_grant   <= w_winner;
            r_gidx    <= w_win_idx;
            r_s_req   <= 1'b1;
            r_s_addr  <= m_addr[int'(w_win_idx)*N +: N];
            r_s_cmd   <= m_cmd[w_win_idx];
            r_s_wdata <= m_wdata[int'(w_win_idx)*N +: N];
            r_state   <= BUSY;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
`endif
          end
        end
        BUSY: begin
`ifdef ARB_TIMEOUT_EN
          r_cnt <= r_cnt + 1'b1;
`endif
          // payload stays in the latch; live master inputs are not looked at here
          if (w_done) begin
            r_s_req <= 1'b0;
            r_m_ack <= r_grant;
            r_grant <= '0;
            r_ptr   <= w_ptr_next;
            r_state <= DONE;
`ifdef ARB_TIMEOUT_EN
            r_m_rdata <= s_ack ? s_rdata : TIMEOUT_DATA;
            r_timeout <= !s_ack;
`else
            r_m_rdata <= s_rdata;
`endif
          end
        end
        DONE: begin
          // no grant here, so a master still holding req after its ack is not re-served
          r_m_ack   <= '0;
          r_m_rdata <= '0;
          r_state   <= IDLE;
`ifdef ARB_TIMEOUT_EN
          r_timeout <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_ack     = r_m_ack;
  assign m_rdata   = r_m_rdata;
  assign s_req     = r_s_req;
  assign s_addr    = r_s_addr;
  assign s_cmd     = r_s_cmd;
  assign s_wdata   = r_s_wdata;
  assign arb_req   = w_elig;
  assign arb_grant = r_grant;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// tb/tb_slave_port_arbiter.sv - scoreboard bench for slave_port_arbiter with directed vectors
module tb_slave_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req;
  logic [63:0] m_addr;
  logic [1:0]  m_cmd;
  logic [63:0] m_wdata;
  logic [1:0]  m_ack;
  logic [31:0] m_rdata;
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_cmd;
  logic [31:0] s_wdata;
  logic        s_ack;
  logic [31:0] s_rdata;
  logic [1:0]  arb_req;
  logic [1:0]  arb_grant;
  logic        timeout;

  always #5 clk = ~clk;

  slave_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m_req     (m_req),
    .m_addr    (m_addr),
    .m_cmd     (m_cmd),
    .m_wdata   (m_wdata),
    .m_ack     (m_ack),
    .m_rdata   (m_rdata),
    .s_req     (s_req),
    .s_addr    (s_addr),
    .s_cmd     (s_cmd),
    .s_wdata   (s_wdata),
    .s_ack     (s_ack),
    .s_rdata   (s_rdata),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .timeout   (timeout)
  );

  typedef struct {
    logic [1:0]  grant;
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
  } sreq_t;

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        to;
    int          gap;
  } ack_t;

  sreq_t q_sreq[$];
  ack_t  q_ack[$];

  int checks = 0;
  int errors = 0;

  int rem [2];
  int slave_lat;
  int scnt;
  bit slave_en;
  bit stray;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_s(input logic [1:0] g, input logic [31:0] a, input logic c, input logic [31:0] d);
    sreq_t e;
    e.grant = g; e.addr = a; e.cmd = c; e.wdata = d;
    q_sreq.push_back(e);
  endtask

  task automatic push_a(input logic [1:0] g, input logic [31:0] rd, input logic to, input int gap);
    ack_t e;
    e.ack = g; e.rdata = rd; e.to = to; e.gap = gap;
    q_ack.push_back(e);
  endtask

  task automatic set_master(input int i, input logic [31:0] a, input logic c, input logic [31:0] d, input int n);
    m_addr[i*32 +: 32]  = a;
    m_cmd[i]            = c;
    m_wdata[i*32 +: 32] = d;
    rem[i]              = n;
  endtask

  // One clock of the master and slave models; all DUT inputs change #1 after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (m_ack[i] && rem[i] > 0) rem[i]--;
      m_req[i] = (rem[i] != 0);
    end
    if (s_ack) begin
      s_ack = 1'b0;
      scnt  = 0;
    end else if (s_req && slave_en) begin
      scnt++;
      if (scnt == slave_lat) s_ack = 1'b1;
    end else begin
      scnt = 0;
    end
    if (stray) begin
      s_ack = 1'b1;
      stray = 1'b0;
    end
  endtask

  task automatic wait_q();
    for (int k = 0; k < 200; k++) begin
      if (q_sreq.size() == 0 && q_ack.size() == 0 && !s_req) break;
      step();
    end
    check("drain_sreq_queue", 64'(q_sreq.size()), 64'd0);
    check("drain_ack_queue", 64'(q_ack.size()), 64'd0);
  endtask

  // Monitor: pops expectations whenever the DUT starts a slave request or acks a master.
  initial begin
    sreq_t cur;
    ack_t  a;
    int    cyc;
    int    rise;
    logic  prev;
    bit    have;
    cyc = 0; rise = 0; prev = 1'b0; have = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (s_req && !prev) begin
        if (q_sreq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_s_req: actual addr %0h grant %0h required no request", s_addr, arb_grant);
          have = 1'b0;
        end else begin
          cur  = q_sreq.pop_front();
          have = 1'b1;
          rise = cyc;
          check("sreq_grant", 64'(arb_grant), 64'(cur.grant));
          check("sreq_addr", 64'(s_addr), 64'(cur.addr));
          check("sreq_cmd", 64'(s_cmd), 64'(cur.cmd));
          check("sreq_wdata", 64'(s_wdata), 64'(cur.wdata));
        end
      end else if (s_req && have) begin
        check("busy_grant", 64'(arb_grant), 64'(cur.grant));
        check("busy_addr", 64'(s_addr), 64'(cur.addr));
        check("busy_wdata", 64'(s_wdata), 64'(cur.wdata));
      end
      if (!s_req) check("idle_grant_zero", 64'(arb_grant), 64'd0);
      if (m_ack != 2'b00) begin
        if (q_ack.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_m_ack: actual %0h required 0", m_ack);
        end else begin
          a = q_ack.pop_front();
          check("m_ack", 64'(m_ack), 64'(a.ack));
          check("m_rdata", 64'(m_rdata), 64'(a.rdata));
          check("timeout_flag", 64'(timeout), 64'(a.to));
          check("ack_gap", 64'(cyc - rise), 64'(a.gap));
        end
      end else begin
        check("rdata_quiet", 64'(m_rdata), 64'd0);
        check("timeout_quiet", 64'(timeout), 64'd0);
      end
      prev = s_req;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual time %0t required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_rdata = '0; slave_en = 1'b1; stray = 1'b0; scnt = 0; slave_lat = 3;
    rem[0] = 0; rem[1] = 0;
    step(); step();
    @(negedge clk);
    check("rst_s_req", 64'(s_req), 64'd0);
    check("rst_grant", 64'(arb_grant), 64'd0);
    check("rst_m_ack", 64'(m_ack), 64'd0);
    check("rst_m_rdata", 64'(m_rdata), 64'd0);
    check("rst_s_addr", 64'(s_addr), 64'd0);
    rst = 1'b0;

    // single master write, latency 1 to s_req
    s_rdata = 32'h5555_0001;
    set_master(0, 32'h0000_0010, 1'b1, 32'h1111_1111, 1);
    push_s(2'b01, 32'h10, 1'b1, 32'h1111_1111);
    push_a(2'b01, 32'h5555_0001, 1'b0, 3);
    step();
    @(negedge clk);
    check("t1_arb_req", 64'(arb_req), 64'd1);
    check("t1_s_req_not_yet", 64'(s_req), 64'd0);
    step();
    @(negedge clk);
    check("t1_s_req_latency", 64'(s_req), 64'd1);
    wait_q(); step();

    // contention after reset: master 0 first, then master 1
    rst = 1'b1; step(); rst = 1'b0;
    s_rdata = 32'hAAAA_AAAA;
    set_master(0, 32'h0000_0100, 1'b0, 32'h0000_00C0, 1);
    set_master(1, 32'h0000_0200, 1'b0, 32'h0000_00C1, 1);
    push_s(2'b01, 32'h100, 1'b0, 32'hC0); push_a(2'b01, 32'hAAAA_AAAA, 1'b0, 3);
    push_s(2'b10, 32'h200, 1'b0, 32'hC1); push_a(2'b10, 32'hAAAA_AAAA, 1'b0, 3);
    step(); wait_q(); step();

    // fairness: both hold req for three transactions each
    s_rdata = 32'h3333_0000;
    set_master(0, 32'h0000_0400, 1'b1, 32'hA0A0_A0A0, 3);
    set_master(1, 32'h0000_0500, 1'b1, 32'hB0B0_B0B0, 3);
    for (int k = 0; k < 3; k++) begin
      push_s(2'b01, 32'h400, 1'b1, 32'hA0A0_A0A0); push_a(2'b01, 32'h3333_0000, 1'b0, 3);
      push_s(2'b10, 32'h500, 1'b1, 32'hB0B0_B0B0); push_a(2'b10, 32'h3333_0000, 1'b0, 3);
    end
    step(); wait_q(); step();

    // decode miss on master 1; stray s_ack while idle must be ignored
    s_rdata = 32'h0000_4444;
    set_master(0, 32'h0000_0020, 1'b0, 32'h0, 1);
    set_master(1, 32'h8000_0000, 1'b0, 32'h0, 1);
    push_s(2'b01, 32'h20, 1'b0, 32'h0); push_a(2'b01, 32'h0000_4444, 1'b0, 3);
    step();
    @(negedge clk);
    check("t4_arb_req_both", 64'(arb_req), 64'd1);
    wait_q();
    @(negedge clk);
    check("t4_arb_req_miss", 64'(arb_req), 64'd0);
    stray = 1'b1;
    step(); step(); step();
    rem[1] = 0;
    step();

    // reset in BUSY: ptr is 1 here, so master 0 winning afterwards shows ptr cleared
    slave_en = 1'b0;
    set_master(1, 32'h0000_0300, 1'b0, 32'h77, 1);
    push_s(2'b10, 32'h300, 1'b0, 32'h77);
    step(); step(); step(); step();
    rem[0] = 0; rem[1] = 0;
    rst = 1'b1; step(); step(); rst = 1'b0;
    @(negedge clk);
    check("t5_s_req", 64'(s_req), 64'd0);
    check("t5_grant", 64'(arb_grant), 64'd0);
    check("t5_m_ack", 64'(m_ack), 64'd0);
    slave_en = 1'b1;
    s_rdata = 32'h5A5A_5A5A;
    set_master(0, 32'h0000_0600, 1'b1, 32'h66, 1);
    set_master(1, 32'h0000_0700, 1'b1, 32'h77, 1);
    push_s(2'b01, 32'h600, 1'b1, 32'h66); push_a(2'b01, 32'h5A5A_5A5A, 1'b0, 3);
    push_s(2'b10, 32'h700, 1'b1, 32'h77); push_a(2'b10, 32'h5A5A_5A5A, 1'b0, 3);
    step(); wait_q(); step();

`ifdef ARB_TIMEOUT_EN
    slave_en = 1'b0;
    set_master(0, 32'h0000_0040, 1'b0, 32'h0, 1);
    push_s(2'b01, 32'h40, 1'b0, 32'h0); push_a(2'b01, 32'hDEAD_BEEF, 1'b1, 16);
    step(); wait_q();
    slave_en = 1'b1;
    step();
`endif

    step(); step();
    check("final_queues", 64'(q_sreq.size() + q_ack.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
